// File: rtl/drain_serializer_if.sv
// Handshake bundle between the D0/D1 output FIFOs, the full logic and the drain serializer.
// slave modport: the serializer (reads FIFO data/flags and active, drives pops, serial lane, counters).
// master modport: the environment (FIFOs + full logic) driving the serializer.
interface drain_serializer_if #(
    parameter int data_width  = 6,
    parameter int count_width = 8
);
    logic                   active;
    logic [data_width-1:0]  data_out_D0;
    logic [data_width-1:0]  data_out_D1;
    logic                   empty_fifo_D0;
    logic                   empty_fifo_D1;
    logic                   D0_pop;
    logic                   D1_pop;
    logic                   serial_out;
    logic                   serial_valid;
    logic                   frame_start;
    logic [count_width-1:0] sent_D0;
    logic [count_width-1:0] sent_D1;

    modport slave (
        input  active, data_out_D0, data_out_D1, empty_fifo_D0, empty_fifo_D1,
        output D0_pop, D1_pop, serial_out, serial_valid, frame_start, sent_D0, sent_D1
    );

    modport master (
        output active, data_out_D0, data_out_D1, empty_fifo_D0, empty_fifo_D1,
        input  D0_pop, D1_pop, serial_out, serial_valid, frame_start, sent_D0, sent_D1
    );
endinterface

// File: rtl/drain_serializer.sv
// Drains D0/D1 FIFOs round-robin and serializes {tag, word} MSB first on a single-bit lane.
// Latency: 3 cycles from a sampled non-empty FIFO (in IDLE, active high) to the tag bit; 10 cycles per word.
// Backpressure: none downstream; new frames start only while active is high, a running frame always completes.
// Ports: clk, reset (async active-high), bus (slave modport: FIFO data/empty, active, pops, serial lane, counters).
module drain_serializer #(
    parameter int data_width  = 6,
    parameter int count_width = 8
) (
    input  logic              clk,
    input  logic              reset,
    drain_serializer_if.slave bus
);
    localparam int bit_cnt_width = $clog2(data_width + 1);
    localparam logic [bit_cnt_width-1:0] last_bit = bit_cnt_width'(data_width);

    typedef enum logic [1:0] {IDLE, POP, CAPTURE, SHIFT} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     sel;          // 0 = D0, 1 = D1; also the frame's tag bit
    logic                     sel_nxt;
    logic                     last_served;
    logic                     frame_done;
    logic [data_width:0]      shreg;
    logic [bit_cnt_width-1:0] bit_cnt;
    logic [count_width-1:0]   sent_d0_q;
    logic [count_width-1:0]   sent_d1_q;

    // State register; sel only changes when leaving IDLE, so it stays stable for the whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.active && !(bus.empty_fifo_D0 && bus.empty_fifo_D1)) begin
                    state_nxt = POP;
                    // Tie goes to the channel not served last; otherwise the only
                    // non-empty one (D0 empty implies D1 is the candidate).
                    if (!bus.empty_fifo_D0 && !bus.empty_fifo_D1)
                        sel_nxt = ~last_served;
                    else
                        sel_nxt = bus.empty_fifo_D0;
                end
            end
            POP:     state_nxt = CAPTURE;
            CAPTURE: state_nxt = SHIFT;
            SHIFT: begin
                if (bit_cnt == last_bit) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            sent_d0_q   <= '0;
            sent_d1_q   <= '0;
            last_served <= 1'b1;
        end else begin
            if (state == CAPTURE) begin
                // Read data is valid here: the pop was issued in the preceding POP cycle.
                shreg   <= {sel, (sel ? bus.data_out_D1 : bus.data_out_D0)};
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg   <= {shreg[data_width-1:0], 1'b0};
                bit_cnt <= bit_cnt + bit_cnt_width'(1);
            end
            // Counted only when the last bit leaves, so a frame cut by reset is never counted.
            if (frame_done) begin
                last_served <= sel;
                if (sel)
                    sent_d1_q <= sent_d1_q + count_width'(1);
                else
                    sent_d0_q <= sent_d0_q + count_width'(1);
            end
        end
    end

    // Every output is decoded from registered state only.
    assign bus.D0_pop       = (state == POP) && !sel;
    assign bus.D1_pop       = (state == POP) && sel;
    assign bus.serial_valid = (state == SHIFT);
    assign bus.serial_out   = (state == SHIFT) && shreg[data_width];
    assign bus.frame_start  = (state == SHIFT) && (bit_cnt == '0);
    assign bus.sent_D0      = sent_d0_q;
    assign bus.sent_D1      = sent_d1_q;
endmodule

// File: tb/tb_drain_serializer.sv
// Bench for drain_serializer: FIFO model on the negedge, frames checked against a queue-based arbitration model.
module tb_drain_serializer;
    localparam int DW = 6;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    drain_serializer_if #(.data_width(DW), .count_width(CW)) bus();
    drain_serializer #(.data_width(DW), .count_width(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops0 = 0, pops1 = 0, both_pops = 0, underflow = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit exp_last = 1'b1;
    int exp_s0 = 0, exp_s1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a pop seen in cycle N presents the next word from mid-cycle N onwards.
    always @(negedge clk) begin
        if (bus.D0_pop && bus.D1_pop) both_pops++;
        if (bus.D0_pop) begin
            pops0++;
            if (q0.size() > 0) bus.data_out_D0 = q0.pop_front(); else underflow++;
        end
        if (bus.D1_pop) begin
            pops1++;
            if (q1.size() > 0) bus.data_out_D1 = q1.pop_front(); else underflow++;
        end
        bus.empty_fifo_D0 = (q0.size() == 0);
        bus.empty_fifo_D1 = (q1.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a frame, records its 7 bits and frame_start flags, ends one cycle past the last bit.
    task automatic capture_frame(output logic [6:0] bits, output logic [6:0] fs,
                                 output int start, output bit got);
        int w = 0;
        got = 1'b0; bits = '0; fs = '0; start = 0;
        while (!bus.serial_valid && w < 60) begin
            tick();
            w++;
        end
        if (bus.serial_valid) begin
            got = 1'b1;
            start = cyc;
            for (int i = 0; i < 7; i++) begin
                bits = {bits[5:0], bus.serial_out};
                fs   = {fs[5:0], bus.frame_start};
                tick();
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] bits, fs;
        logic [DW-1:0] w0, w1;
        int st, n;
        bit got;
        bus.active = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.D0_pop, bus.D1_pop, bus.serial_out, bus.serial_valid, bus.frame_start,
             bus.sent_D0, bus.sent_D1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got pops=%b%b sv=%b so=%b fs=%b s0=%0d s1=%0d, want all 0",
                     bus.D0_pop, bus.D1_pop, bus.serial_valid, bus.serial_out, bus.frame_start,
                     bus.sent_D0, bus.sent_D1);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Mid-frame reset during bit 3
        q0.push_back(DW'($urandom));
        bus.active = 1'b1;
        n = 0;
        while (!bus.serial_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.serial_valid) begin
            errors++;
            $display("FAIL reset_frame_start: no frame seen within %0d cycles, want one", n);
            return;
        end
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.D0_pop, bus.D1_pop, bus.serial_out, bus.serial_valid, bus.frame_start,
             bus.sent_D0, bus.sent_D1} !== '0) begin
            errors++;
            $display("FAIL reset_midframe: got sv=%b so=%b fs=%b s0=%0d s1=%0d, want all 0",
                     bus.serial_valid, bus.serial_out, bus.frame_start, bus.sent_D0, bus.sent_D1);
        end
        tick();
        reset = 1'b0;
        exp_last = 1'b1;
        exp_s0 = 0;
        exp_s1 = 0;

        // Tie after release must serve D0 first
        bus.active = 1'b0;
        w0 = DW'($urandom);
        w1 = DW'($urandom);
        q0.push_back(w0);
        q1.push_back(w1);
        repeat (2) tick();
        bus.active = 1'b1;
        capture_frame(bits, fs, st, got);
        checks++;
        if (!got || bits !== {1'b0, w0}) begin
            errors++;
            $display("FAIL reset_tie_first: got frame %b (seen=%0d), want %b", bits, got, {1'b0, w0});
        end
        capture_frame(bits, fs, st, got);
        checks++;
        if (!got || bits !== {1'b1, w1}) begin
            errors++;
            $display("FAIL reset_tie_second: got frame %b (seen=%0d), want %b", bits, got, {1'b1, w1});
        end
        exp_s0 = 1; exp_s1 = 1; exp_last = 1'b1;
        checks++;
        if (bus.sent_D0 !== CW'(exp_s0) || bus.sent_D1 !== CW'(exp_s1)) begin
            errors++;
            $display("FAIL reset_counts: got s0=%0d s1=%0d, want %0d %0d", bus.sent_D0, bus.sent_D1, exp_s0, exp_s1);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] e0[$];
        logic [DW-1:0] e1[$];
        logic [6:0] exp_frames[$];
        logic [6:0] bits, fs;
        int st, prev_st, c0, c1, bp0;
        bit got, t;
        bus.active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e0.push_back(DW'($urandom));
            e1.push_back(DW'($urandom));
            q0.push_back(e0[i]);
            q1.push_back(e1[i]);
        end
        // Model: alternate on ties, otherwise take whichever channel still holds words.
        c0 = 3; c1 = 3;
        while (c0 > 0 || c1 > 0) begin
            if (c0 > 0 && c1 > 0) t = !exp_last;
            else t = (c0 == 0);
            if (t) begin exp_frames.push_back({1'b1, e1.pop_front()}); c1--; exp_s1++; end
            else   begin exp_frames.push_back({1'b0, e0.pop_front()}); c0--; exp_s0++; end
            exp_last = t;
        end
        bp0 = both_pops;
        repeat (2) tick();
        bus.active = 1'b1;
        prev_st = 0;
        for (int k = 0; k < 6; k++) begin
            capture_frame(bits, fs, st, got);
            checks++;
            if (!got || bits !== exp_frames[k]) begin
                errors++;
                $display("FAIL rr_frame%0d: got %b (seen=%0d), want %b", k, bits, got, exp_frames[k]);
            end
            if (k > 0) begin
                checks++;
                if (st - prev_st != 10) begin
                    errors++;
                    $display("FAIL rr_period%0d: got %0d cycles between tag bits, want 10", k, st - prev_st);
                end
            end
            prev_st = st;
        end
        checks++;
        if (both_pops != bp0) begin
            errors++;
            $display("FAIL rr_simul_pop: got %0d simultaneous pops, want 0", both_pops - bp0);
        end
        checks++;
        if (bus.sent_D0 !== CW'(exp_s0) || bus.sent_D1 !== CW'(exp_s1)) begin
            errors++;
            $display("FAIL rr_counts: got s0=%0d s1=%0d, want %0d %0d", bus.sent_D0, bus.sent_D1, exp_s0, exp_s1);
        end
    endtask

    task automatic test_single_d0();
        logic [6:0] bits, fs;
        int st, n, p0, p1;
        bit got;
        bus.active = 1'b1;
        tick();
        p0 = pops0; p1 = pops1;
        q0.push_back(6'b110101);
        n = 0;
        while (!bus.serial_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles to first bit, want 3", n);
        end
        capture_frame(bits, fs, st, got);
        checks++;
        if (!got || bits !== 7'b0110101) begin
            errors++;
            $display("FAIL single_bits: got %b (seen=%0d), want 0110101", bits, got);
        end
        checks++;
        if (fs !== 7'b1000000) begin
            errors++;
            $display("FAIL single_frame_start: got %b, want 1000000", fs);
        end
        exp_s0++;
        exp_last = 1'b0;
        checks++;
        if (bus.serial_valid !== 1'b0 || bus.sent_D0 !== CW'(exp_s0) || bus.sent_D1 !== CW'(exp_s1)) begin
            errors++;
            $display("FAIL single_counts: got sv=%b s0=%0d s1=%0d, want 0 %0d %0d",
                     bus.serial_valid, bus.sent_D0, bus.sent_D1, exp_s0, exp_s1);
        end
        checks++;
        if (pops0 - p0 != 1 || pops1 != p1) begin
            errors++;
            $display("FAIL single_pops: got d0=%0d d1=%0d pop cycles, want 1 0", pops0 - p0, pops1 - p1);
        end
    endtask

    task automatic test_active_drop();
        logic [DW-1:0] w1, w2;
        logic [6:0] bits, fs;
        int st, n, p1, vcnt;
        bit got;
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        bus.active = 1'b1;
        q1.push_back(w1);
        q1.push_back(w2);
        n = 0;
        while (!bus.serial_valid && n < 40) begin
            tick();
            n++;
        end
        bits = '0;
        for (int i = 0; i < 7; i++) begin
            bits = {bits[5:0], bus.serial_out};
            if (i == 2) bus.active = 1'b0;
            tick();
        end
        exp_s1++;
        exp_last = 1'b1;
        checks++;
        if (bits !== {1'b1, w1} || bus.sent_D1 !== CW'(exp_s1)) begin
            errors++;
            $display("FAIL drop_complete: got frame %b s1=%0d, want %b %0d", bits, bus.sent_D1, {1'b1, w1}, exp_s1);
        end
        p1 = pops1;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.serial_valid) vcnt++;
            tick();
        end
        checks++;
        if (pops1 != p1 || vcnt != 0) begin
            errors++;
            $display("FAIL drop_hold: got %0d pops %0d valid cycles while inactive, want 0 0", pops1 - p1, vcnt);
        end
        bus.active = 1'b1;
        n = 0;
        while (!bus.serial_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL drop_resume: got %0d cycles to first bit, want 3", n);
        end
        capture_frame(bits, fs, st, got);
        exp_s1++;
        checks++;
        if (!got || bits !== {1'b1, w2} || bus.sent_D1 !== CW'(exp_s1)) begin
            errors++;
            $display("FAIL drop_second: got %b s1=%0d, want %b %0d", bits, bus.sent_D1, {1'b1, w2}, exp_s1);
        end
    endtask

    task automatic test_empty_idle();
        int p0, p1, vcnt;
        bus.active = 1'b1;
        p0 = pops0; p1 = pops1; vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.serial_valid) vcnt++;
        end
        checks++;
        if (pops0 != p0 || pops1 != p1 || vcnt != 0) begin
            errors++;
            $display("FAIL empty_idle: got pops=%0d/%0d valid=%0d, want 0/0 0", pops0 - p0, pops1 - p1, vcnt);
        end
        checks++;
        if (bus.sent_D0 !== CW'(exp_s0) || bus.sent_D1 !== CW'(exp_s1)) begin
            errors++;
            $display("FAIL empty_counts: got s0=%0d s1=%0d, want %0d %0d", bus.sent_D0, bus.sent_D1, exp_s0, exp_s1);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] e0[$];
        logic [DW-1:0] w;
        logic [6:0] bits, fs;
        int st;
        bit got;
        bus.active = 1'b0;
        #3 reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_s0 = 0; exp_s1 = 0; exp_last = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = DW'($urandom);
            e0.push_back(w);
            q0.push_back(w);
        end
        repeat (2) tick();
        bus.active = 1'b1;
        for (int k = 0; k < 256; k++) begin
            capture_frame(bits, fs, st, got);
            w = e0.pop_front();
            checks++;
            if (!got || bits !== {1'b0, w}) begin
                errors++;
                $display("FAIL wrap_frame%0d: got %b (seen=%0d), want %b", k, bits, got, {1'b0, w});
                return;
            end
            exp_s0 = (exp_s0 + 1) % 256;
            if (k == 254) begin
                checks++;
                if (bus.sent_D0 !== CW'(255)) begin
                    errors++;
                    $display("FAIL wrap_255: got s0=%0d, want 255", bus.sent_D0);
                end
            end
        end
        checks++;
        if (bus.sent_D0 !== CW'(exp_s0) || bus.sent_D1 !== CW'(0)) begin
            errors++;
            $display("FAIL wrap_final: got s0=%0d s1=%0d, want %0d 0", bus.sent_D0, bus.sent_D1, exp_s0);
        end
    endtask

    initial begin
        bus.active = 1'b0;
        test_reset();
        test_round_robin();
        test_single_d0();
        test_active_drop();
        test_empty_idle();
        test_wrap();
        checks++;
        if (underflow != 0) begin
            errors++;
            $display("FAIL fifo_underflow: got %0d pops from an empty FIFO, want 0", underflow);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/drain_serializer.md
# drain_serializer

Downstream consumer of the D0/D1 output FIFOs of the transmission full logic. It pops words from the two destination FIFOs with round-robin arbitration and serializes each word, MSB first, onto a single-bit lane prefixed by a channel tag. It keeps per-channel transmitted-word counters for the bench and for link statistics. Draining is gated by the `active` state of the full logic.

## Interface

Parameters:
- `data_width`, 6: width of a FIFO word.
- `count_width`, 8: width of each transmitted-word counter.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `active` in 1: from full logic `active_out`; new frames start only while high.
- `data_out_D0` in `data_width`: D0 FIFO read data.
- `data_out_D1` in `data_width`: D1 FIFO read data.
- `empty_fifo_D0` in 1: D0 FIFO empty flag.
- `empty_fifo_D1` in 1: D1 FIFO empty flag.
- `D0_pop` out 1: one-cycle read strobe to the D0 FIFO.
- `D1_pop` out 1: one-cycle read strobe to the D1 FIFO.
- `serial_out` out 1: serialized bit.
- `serial_valid` out 1: high while `serial_out` carries a frame bit.
- `frame_start` out 1: high on the first bit of each frame.
- `sent_D0` out `count_width`: words fully transmitted from D0.
- `sent_D1` out `count_width`: words fully transmitted from D1.

## Operation

- FIFO read contract:
  - A pop asserted during cycle N presents the word on `data_out_Dx` during cycle N+1.
  - Empty flags update on the edge ending cycle N.
- The FSM has four states: IDLE, POP, CAPTURE and SHIFT.
- IDLE:
  - Outputs: `serial_valid`=0, `serial_out`=0, no pops.
  - On an edge with `active`=1 and at least one FIFO non-empty, select a channel and go to POP.
- Arbitration:
  - Only one FIFO non-empty: select it.
  - Both non-empty: select the channel opposite `last_served`.
  - `last_served` resets to 1, so D0 wins the first tie.
- POP: assert exactly the selected `Dx_pop` for one cycle, then go to CAPTURE. The two pops are never high together.
- CAPTURE: on the edge, load the 7-bit shift register with {sel, data_out_Dsel}, clear the bit counter, and go to SHIFT.
- SHIFT:
  - `serial_out` = shreg[6] and `serial_valid`=1; `frame_start`=1 when the bit counter is 0.
  - Each edge shifts left and increments the bit counter.
  - On the edge leaving bit 6:
    - increment `sent_Dsel` (wraps 255→0);
    - set `last_served` = sel;
    - return to IDLE.
- Frame format, 7 bits: channel tag (0=D0, 1=D1), then data[5] … data[0].
- `active` falling mid-frame does not abort the frame. The frame completes, and no new frame starts until `active` returns high.
- Empty flags are sampled only in IDLE. This block is the sole reader, so a sampled non-empty FIFO cannot underflow.
- Asynchronous `reset` takes effect at any point, including mid-frame:
  - state goes to IDLE and the shift register, bit counter and both counters go to 0;
  - all outputs go to 0;
  - `last_served` goes to 1.
  
  A partial frame is dropped and not counted.

## Timing

- Reset value of every output is 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Edge E0 in IDLE with the condition met:
  - cycle after E0: POP;
  - next cycle: CAPTURE;
  - next 7 cycles: SHIFT, tag bit first.
- Per-word period: 10 cycles (IDLE, POP, CAPTURE, 7× SHIFT).
- Latency from `empty` falling to the first `serial_valid` is 3 cycles when `active`=1 and the block is in IDLE.
- `sent_Dx` updates on the same edge that deasserts `serial_valid` for that frame.
- Back-to-back frames have at least one cycle of `serial_valid`=0 (IDLE) and at least 3 cycles between the last bit and the next tag bit.

## Test plan

- Reset mid-frame: assert `reset` asynchronously during bit 3 of a frame.
  - All outputs go to 0 before the next edge.
  - Counters stay 0.
  - The next D0/D1 tie after release serves D0.
- Single D0 word, 6'b110101, `active`=1:
  - `D0_pop` is high for exactly one cycle.
  - `serial_out` sequence is 0,1,1,0,1,0,1 with `frame_start` on the first bit only.
  - `sent_D0`=1 and `sent_D1`=0.
- Both FIFOs holding 3 words each:
  - Frames alternate D0, D1, D0, D1, D0, D1 (tags 0,1,0,1,0,1).
  - Pops are never simultaneous.
  - Final `sent_D0`=`sent_D1`=3.
- `active` dropped at bit 2 of a D1 frame with more data pending:
  - The frame completes and `sent_D1` increments.
  - No further pop until `active`=1 again; popping then resumes within 3 cycles of `serial_valid`.
- Both FIFOs empty with `active`=1 for 20 cycles:
  - No pops.
  - `serial_valid`=0 throughout.
  - Counters unchanged.
- 256 D0 words: `sent_D0` wraps to 0 on the 256th frame and `sent_D1` stays 0.
